tinyalu_cmd_issuer: RTL

TINYALU_CMD_ISSUER -- requirements
Module: tinyalu_cmd_issuer

---
 rtl/tinyalu_cmd_issuer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/tinyalu_cmd_issuer.sv
// Command issuer for a TinyALU: buffers commands in a small FIFO, issues them one
// at a time to the ALU, filters illegal opcodes, and returns results or timeout aborts.
module tinyalu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        alu_start,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic [7:0]  illegal_cnt,
    output logic        busy
);

    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW    = $clog2(FIFO_DEPTH + 1);
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int ENTRY_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic [TW-1:0]       r_tmo;
    logic                r_alu_start;
    logic [7:0]          r_alu_a;
    logic [7:0]          r_alu_b;
    logic [2:0]          r_alu_op;
    logic                r_rsp_valid;
    logic [15:0]         r_rsp_result;
    logic [2:0]          r_rsp_op;
    logic                r_rsp_err;
    logic [7:0]          r_illegal;

    logic                w_full;
    logic                w_not_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_head;
    logic [7:0]          w_head_a;
    logic [7:0]          w_head_b;
    logic [2:0]          w_head_op;

    // Readiness derives from the current occupancy only, so a pop while full never admits a push that cycle.
    assign w_full      = (r_count == CNTW'(FIFO_DEPTH));
    assign w_not_empty = (r_count != {CNTW{1'b0}});
    assign w_push      = cmd_valid && !w_full;
    assign w_pop       = (r_state == ST_IDLE) && w_not_empty;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_a    = w_head[18:11];
    assign w_head_b    = w_head[10:3];
    assign w_head_op   = w_head[2:0];

    assign cmd_ready   = !w_full;
    assign busy        = (r_state != ST_IDLE) || w_not_empty;
    assign alu_start   = r_alu_start;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_op      = r_rsp_op;
    assign rsp_err     = r_rsp_err;
    assign illegal_cnt = r_illegal;

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {ENTRY_W{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CNTW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: one command in flight, all ALU and response outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_tmo        <= {TW{1'b0}};
            r_alu_start  <= 1'b0;
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_op     <= 3'b000;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_op     <= 3'b000;
            r_rsp_err    <= 1'b0;
            r_illegal    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_not_empty) begin
                        if (w_head_op > 3'd4) begin
                            if (r_illegal != 8'hFF) begin
                                r_illegal <= r_illegal + 8'd1;
                            end
                        end else begin
                            r_alu_start <= 1'b1;
                            r_alu_a     <= w_head_a;
                            r_alu_b     <= w_head_b;
                            r_alu_op    <= w_head_op;
                            r_tmo       <= {TW{1'b0}};
                            r_state     <= (w_head_op == 3'd0) ? ST_NOP : ST_WAIT;
                        end
                    end
                end
                ST_NOP: begin
                    r_alu_start <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                ST_WAIT: begin
                    // A completion on the final timeout cycle still wins over the abort.
                    if (alu_done) begin
                        r_alu_start  <= 1'b0;
                        r_rsp_result <= alu_result;
                        r_rsp_op     <= r_alu_op;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_tmo == TW'(TIMEOUT)) begin
                        r_alu_start  <= 1'b0;
                        r_rsp_result <= 16'h0000;
                        r_rsp_op     <= r_alu_op;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_alu_start <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
